dmem_port_arbiter: RTL and testbench

//  Shares the single-ported data memory between the pipeline MEM stage (CPU) and a debug/loader port (DBG).
//  - Grants one access at a time and sequences it over the fixed memory latency.
//  - Stalls the pipeline while a CPU access is pending.
//  - Sits between the MEM stage / bench loader and the data-memory instance.

---
 rtl/dmem_arb_pkg.sv | 28 ++
 rtl/dmem_arb_pick.sv | 27 ++
 rtl/dmem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter.
// State and owner encodings, latched request bundle, default parameters.
package dmem_arb_pkg;

  localparam int DEF_AW         = 32;
  localparam int DEF_DW         = 32;
  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DBG
  } owner_t;

  typedef struct packed {
    logic                  we;
    logic [DEF_AW-1:0]     addr;
    logic [DEF_DW-1:0]     wdata;
    logic [DEF_DW/8-1:0]   be;
  } mem_req_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between CPU and DBG requesters.
// A masked requester still contends but cannot be granted this cycle.
module dmem_arb_pick (
  input  logic cpu_req,
  input  logic dbg_req,
  input  logic cpu_mask,
  input  logic dbg_mask,
  input  logic starve_hit,
  output logic grant_cpu,
  output logic grant_dbg
);

  logic pick_dbg;

  always_comb begin
    pick_dbg = 1'b0;
    unique case (1'b1)
      (cpu_req & dbg_req):  pick_dbg = starve_hit;
      (dbg_req & ~cpu_req): pick_dbg = 1'b1;
      default:              pick_dbg = 1'b0;
    endcase
  end

  assign grant_cpu = cpu_req & ~pick_dbg & ~cpu_mask;
  assign grant_dbg = dbg_req &  pick_dbg & ~dbg_mask;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory arbiter: CPU MEM stage vs debug/loader port.
// Define DMEM_ARB_PERF_EN to add access and stall performance counters.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  input  logic [DW/8-1:0] cpu_be,
  output logic [DW-1:0]   cpu_rdata,
  output logic            cpu_done,
  output logic            cpu_stall,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [DW-1:0]   dbg_wdata,
  input  logic [DW/8-1:0] dbg_be,
  output logic [DW-1:0]   dbg_rdata,
  output logic            dbg_done,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]     perf_cpu_acc,
  output logic [31:0]     perf_dbg_acc,
  output logic [31:0]     perf_stall_cyc
`endif
);

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  state_t         state;
  owner_t         owner;
  mem_req_t       req_q;
  mem_req_t       cpu_f;
  mem_req_t       dbg_f;
  logic [LW-1:0]  lat_cnt;
  logic [SW-1:0]  starve_cnt;
  logic           starve_hit;
  logic           grant_cpu;
  logic           grant_dbg;
  logic           in_idle;

  assign cpu_f = '{we: cpu_we, addr: cpu_addr,
                   wdata: cpu_wdata, be: cpu_be};
  assign dbg_f = '{we: dbg_we, addr: dbg_addr,
                   wdata: dbg_wdata, be: dbg_be};

  assign starve_hit = (starve_cnt == SW'(STARVE_MAX));
  assign in_idle    = (state == IDLE);

  // A port whose done is showing is still holding req; never reissue it.
  dmem_arb_pick u_pick (
    .cpu_req    (cpu_req & in_idle),
    .dbg_req    (dbg_req & in_idle),
    .cpu_mask   (cpu_done),
    .dbg_mask   (dbg_done),
    .starve_hit (starve_hit),
    .grant_cpu  (grant_cpu),
    .grant_dbg  (grant_dbg)
  );

  assign mem_we    = req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_be    = req_q.be;
  assign cpu_stall = cpu_req & ~cpu_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_CPU;
      req_q      <= '0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      cpu_done   <= 1'b0;
      dbg_done   <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      mem_en    <= 1'b0;
      cpu_done  <= 1'b0;
      dbg_done  <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      unique case (state)
        IDLE: begin
          if (grant_cpu | grant_dbg) begin
            state  <= ISSUE;
            mem_en <= 1'b1;
            owner  <= grant_dbg ? OWN_DBG : OWN_CPU;
            req_q  <= grant_dbg ? dbg_f : cpu_f;
            if (grant_dbg | ~dbg_req)
              starve_cnt <= '0;
            else if (!starve_hit)
              starve_cnt <= starve_cnt + SW'(1);
          end
        end
        ISSUE: begin
          state   <= WAIT;
          lat_cnt <= LW'(MEM_LAT);
        end
        WAIT: begin
          if (lat_cnt == LW'(1)) begin
            state <= IDLE;
            if (owner == OWN_DBG) begin
              dbg_done  <= 1'b1;
              dbg_rdata <= req_q.we ? '0 : mem_rdata;
            end else begin
              cpu_done  <= 1'b1;
              cpu_rdata <= req_q.we ? '0 : mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cpu_acc   <= '0;
      perf_dbg_acc   <= '0;
      perf_stall_cyc <= '0;
    end else begin
      perf_cpu_acc   <= perf_cpu_acc + 32'(cpu_done);
      perf_dbg_acc   <= perf_dbg_acc + 32'(dbg_done);
      perf_stall_cyc <= perf_stall_cyc + 32'(cpu_stall);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a one-cycle memory model.
// Directed scenarios: load, store, contention, late request, reset.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rdata;
  logic        cpu_done, cpu_stall;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic [3:0]  dbg_be;
  logic [31:0] dbg_rdata;
  logic        dbg_done;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_cpu_acc, perf_dbg_acc, perf_stall_cyc;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          dbg;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_be    (cpu_be),
    .cpu_rdata (cpu_rdata),
    .cpu_done  (cpu_done),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_be    (dbg_be),
    .dbg_rdata (dbg_rdata),
    .dbg_done  (dbg_done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_cpu_acc   (perf_cpu_acc),
    .perf_dbg_acc   (perf_dbg_acc),
    .perf_stall_cyc (perf_stall_cyc)
`endif
  );

  // Memory model with MEM_LAT = 1: read data registered on the strobe edge.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we && mem_be[b])
          mem[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      mem_rdata <= mem[mem_addr[7:2]];
    end
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (cpu_done || dbg_done)) begin
      check("done_exclusive", {31'd0, cpu_done & dbg_done}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_owner", {31'd0, dbg_done}, {31'd0, e.dbg});
        check("rdata", dbg_done ? dbg_rdata : cpu_rdata, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input bit dbg, input bit we,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        input logic [3:0]  be,
                        input logic [31:0] exp);
    int n, en_cnt, en_at;
    bit seen;
    exp_t e;
    e.dbg  = dbg;
    e.data = we ? 32'd0 : exp;
    sb.push_back(e);
    if (dbg) begin
      dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
      dbg_be = be; dbg_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      cpu_be = be; cpu_req = 1'b1;
    end
    n = 0; en_cnt = 0; en_at = 0; seen = 0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      n++;
      if (mem_en) begin
        en_cnt++;
        en_at = n;
      end
      seen = dbg ? dbg_done : cpu_done;
    end
    check("latency", n - 1, 3);
    check("mem_en_count", en_cnt, 1);
    check("mem_en_cycle", en_at, 2);
    step();
    if (dbg) dbg_req = 1'b0;
    else     cpu_req = 1'b0;
  endtask

  task automatic push_exp(input bit dbg, input logic [31:0] d);
    exp_t e;
    e.dbg  = dbg;
    e.data = d;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[4] = 32'hDEAD_BEEF;
    mem[8] = 32'hAAAA_AAAA;
    mem_rdata = '0;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_be = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_be = 0;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mem_en", {31'd0, mem_en}, 0);
    check("rst_done", {30'd0, cpu_done, dbg_done}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rdata", cpu_rdata | dbg_rdata, 0);
    step();

    // 1: plain CPU load
    access(0, 0, 32'h10, 0, 4'hF, 32'hDEAD_BEEF);
    // 2: partial store then load back
    access(0, 1, 32'h20, 32'h1234_5678, 4'b0011, 0);
    access(0, 0, 32'h20, 0, 4'hF, 32'hAAAA_5678);

    // 4: DBG alone, CPU arrives during WAIT
    push_exp(1, 32'hC0DE_000C);
    push_exp(0, 32'hC0DE_000D);
    dbg_we = 0; dbg_addr = 32'h30; dbg_req = 1'b1;
    step();
    @(negedge clk);
    check("s4_dbg_issue", mem_addr, 32'h30);
    step();
    cpu_we = 0; cpu_addr = 32'h34; cpu_req = 1'b1;
    @(negedge clk);
    check("s4_stall_wait", {31'd0, cpu_stall}, 1);
    step();
    @(negedge clk);
    check("s4_dbg_done", {31'd0, dbg_done}, 1);
    check("s4_stall_dbgdone", {31'd0, cpu_stall}, 1);
    step();
    dbg_req = 1'b0;
    @(negedge clk);
    check("s4_cpu_issue_en", {31'd0, mem_en}, 1);
    check("s4_cpu_issue_addr", mem_addr, 32'h34);
    check("s4_stall_issue", {31'd0, cpu_stall}, 1);
    step();
    @(negedge clk);
    check("s4_stall_wait2", {31'd0, cpu_stall}, 1);
    step();
    @(negedge clk);
    check("s4_cpu_done", {31'd0, cpu_done}, 1);
    check("s4_stall_done", {31'd0, cpu_stall}, 0);
    step();
    cpu_req = 1'b0;
    step();

    // 5: reset while a load is in WAIT
    cpu_we = 0; cpu_addr = 32'h14; cpu_req = 1'b1;
    step();
    step();
    reset = 1'b1;
    cpu_req = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("s5_mem_en", {31'd0, mem_en}, 0);
    check("s5_done", {30'd0, cpu_done, dbg_done}, 0);
    check("s5_rdata", cpu_rdata, 0);
    check("s5_mem_addr", mem_addr, 0);
    check("s5_stall", {31'd0, cpu_stall}, 0);
    step();
    step();
    access(0, 0, 32'h14, 0, 4'hF, 32'hC0DE_0005);

    // 3: both ports requesting back to back
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++)
        push_exp(0, 32'hC0DE_0010 | (g * 4 + k));
      push_exp(1, 32'hC0DE_0020 | g);
    end
    fork
      begin
        bit seen;
        int n;
        cpu_we = 0;
        for (int k = 0; k < 16; k++) begin
          cpu_addr = 32'h40 + 32'(k * 4);
          cpu_req  = 1'b1;
          n = 0; seen = 0;
          while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            seen = cpu_done;
          end
          if (!seen) check("s3_cpu_timeout", 1, 0);
          step();
        end
        cpu_req = 1'b0;
      end
      begin
        bit seen;
        int n;
        dbg_we = 0;
        for (int g = 0; g < 4; g++) begin
          dbg_addr = 32'h80 + 32'(g * 4);
          dbg_req  = 1'b1;
          n = 0; seen = 0;
          while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            seen = dbg_done;
          end
          if (!seen) check("s3_dbg_timeout", 1, 0);
          step();
        end
        dbg_req = 1'b0;
      end
    join
    step();
    step();
    check("sb_drained", sb.size(), 0);
`ifdef DMEM_ARB_PERF_EN
    check("perf_cpu_acc", perf_cpu_acc, 16);
    check("perf_dbg_acc", perf_dbg_acc, 4);
    check("perf_stall_cyc", perf_stall_cyc, 54);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
